rx_packet_assembler: RTL and testbench
======================================

RX_PACKET_ASSEMBLER -- requirements
Module: rx_packet_assembler

Interface
REQ-001 Parameter CHK_KEY, default 8'h37, XOR key used to validate the check byte.
REQ-002 Parameter TIMEOUT_CYCLES, default 500000, number of clock cycles allowed between the data byte and the check byte.
REQ-003 Port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx_dv  input  1  one-cycle strobe from the UART receiver; marks rx_byte as valid.
REQ-006 Port rx_byte  input  8  received UART byte, sampled only when rx_dv=1.
REQ-007 Port pkt_ready  input  1  downstream arbiter accepts the held packet when pkt_ready=1 and pkt_valid=1.
REQ-008 Port pkt_valid  output  1  a packet is held in the output buffer.
REQ-009 Port pkt_data  output  8  data byte of the held packet.
REQ-010 Port pkt_chk_ok  output  1  the held packet's check byte equals pkt_data ^ CHK_KEY.
REQ-011 Port timeout_err  output  1  one-cycle pulse; partial packet discarded on timeout.
REQ-012 Port overrun_err  output  1  one-cycle pulse; completed packet dropped because the buffer was full.
REQ-013 Port busy  output  1  high while in WAIT_CHK.

Function
REQ-014 The block SHALL implement two states, IDLE and WAIT_CHK, with IDLE after reset.
REQ-015 IDLE with rx_dv=1 SHALL latch rx_byte as the data byte, load the timer with TIMEOUT_CYCLES and enter WAIT_CHK.
REQ-016 WAIT_CHK with rx_dv=1 SHALL treat rx_byte as the check byte, complete the packet and return to IDLE.
REQ-017 WAIT_CHK SHALL decrement the timer every cycle in which rx_dv=0; at the TIMEOUT_CYCLES-th such cycle it SHALL pulse timeout_err for one cycle, discard the data byte and return to IDLE.
REQ-018 When rx_dv=1 arrives in the same cycle the timer expires, the byte SHALL win: the packet completes and timeout_err stays 0.
REQ-019 Packet completion SHALL compute chk_ok = (check byte == data byte ^ CHK_KEY); failing packets SHALL still be delivered, with pkt_chk_ok=0.
REQ-020 When the buffer is empty, or is being drained in the same cycle (pkt_valid & pkt_ready), a completed packet SHALL load the buffer; pkt_valid rises on the clock edge after the check-byte rx_dv cycle.
REQ-021 When the buffer is full and not being drained, a completed packet SHALL be dropped, the held packet SHALL be kept unchanged, and overrun_err SHALL pulse for one cycle.
REQ-022 pkt_valid & pkt_ready with no packet completing SHALL clear pkt_valid on the next edge.
REQ-023 pkt_data and pkt_chk_ok SHALL stay stable while pkt_valid=1 and pkt_ready=0.
REQ-024 rx_dv SHALL be treated as a single-cycle strobe; a strobe held for N cycles SHALL be consumed as N bytes.
REQ-025 Latency: check-byte strobe to pkt_valid = 1 cycle; expiry cycle to timeout_err = 1 cycle (registered).

Reset
REQ-026 reset=1 SHALL immediately force IDLE, timer=0, buffer empty, and pkt_valid, pkt_data, pkt_chk_ok, timeout_err, overrun_err and busy all 0.
REQ-027 Reset asserted in mid-packet SHALL discard the partial packet, with no error pulse on release.
REQ-028 The first rx_dv sampled after reset release SHALL be treated as a data byte.

Structure
REQ-029 Package sensor_link_pkg SHALL hold the CHK_KEY default, the byte width, the state encoding and the TIMEOUT_CYCLES default, shared with the arbiter.
REQ-030 The timeout counter SHALL be one sub-module, link_timer, with ports clock, reset, load, hold, expired and parameter TIMEOUT_CYCLES.
REQ-031 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1); all remaining logic SHALL live in rx_packet_assembler.

Verification (TIMEOUT_CYCLES=16)
REQ-032 Good packet: rx_byte 8'h5A then 8'h6D (5A^37), pkt_ready=1 -> one cycle after the second strobe pkt_valid=1, pkt_data=8'h5A, pkt_chk_ok=1.
REQ-033 Bad checksum: 8'h10 then 8'hFF -> pkt_valid=1, pkt_data=8'h10, pkt_chk_ok=0, no error pulses.
REQ-034 Timeout and race: 8'h22, then 16 idle cycles -> one timeout_err pulse, busy=0, pkt_valid=0; repeat with the second byte on exactly cycle 16 -> packet delivered, timeout_err=0.
REQ-035 Overrun: pkt_ready=0; packets (8'h01, 8'h36) then (8'h02, 8'h35) -> pkt_data stays 8'h01, overrun_err pulses once; raising pkt_ready with a packet completing the same cycle -> new packet loaded, no overrun.
REQ-036 Reset mid-packet: 8'h44, then reset pulse, then 8'hAA, 8'h9D -> pkt_data=8'hAA, pkt_chk_ok=1, no timeout_err.

Source files
------------

// File: rtl/sensor_link_pkg.sv
// Shared definitions for the sensor link: byte width, check key, timeout default
// and the receive FSM state encoding.
package sensor_link_pkg;

  localparam int               BYTE_W          = 8;
  localparam logic [BYTE_W-1:0] CHK_KEY_DEFAULT = 8'h37;
  localparam int               TIMEOUT_DEFAULT = 500000;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_CHK = 1'b1
  } link_state_t;

  // A packet is good when its check byte equals the data byte XOR the link key.
  function automatic logic chk_match(input logic [BYTE_W-1:0] data,
                                     input logic [BYTE_W-1:0] chk,
                                     input logic [BYTE_W-1:0] key);
    return (chk == (data ^ key));
  endfunction

endpackage

// File: rtl/link_timer.sv
// Down-counter bounding the gap between the data byte and the check byte.
// expired flags the last permitted idle cycle so the caller can register the error.
module link_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic hold,
  output logic expired
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] count_r;

  // Counter register: load wins, otherwise count down on each non-held cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= LOAD_VAL;
    end else if (!hold && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // The cycle that would take the counter from one to zero is the expiry cycle.
  always_comb begin
    expired = 1'b0;
    if (!load && !hold && (count_r == CNT_ONE)) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/rx_packet_assembler.sv
// Assembles two-byte (data, check) packets from a UART byte strobe into a
// single-entry output buffer, with timeout and overrun reporting.
module rx_packet_assembler
  import sensor_link_pkg::*;
#(
  parameter logic [BYTE_W-1:0] CHK_KEY        = CHK_KEY_DEFAULT,
  parameter int                TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              pkt_ready,
  output logic              pkt_valid,
  output logic [BYTE_W-1:0] pkt_data,
  output logic              pkt_chk_ok,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic              busy
);

  link_state_t       state_r;
  link_state_t       state_next_s;
  logic [BYTE_W-1:0] data_r;
  logic              pkt_valid_r;
  logic [BYTE_W-1:0] pkt_data_r;
  logic              pkt_chk_ok_r;
  logic              timeout_err_r;
  logic              overrun_err_r;
  logic              busy_r;

  logic              load_s;
  logic              hold_s;
  logic              expired_s;
  logic              complete_s;
  logic              timeout_s;
  logic              drain_s;
  logic              accept_s;

  // The timer only runs while waiting for the check byte and no byte arrives.
  assign hold_s = (state_r != ST_WAIT_CHK) || rx_dv;

  link_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_link_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .hold    (hold_s),
    .expired (expired_s)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; an arriving byte takes priority over timer expiry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_dv) begin
          state_next_s = ST_WAIT_CHK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_CHK: begin
        if (rx_dv || expired_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_CHK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: data latch, packet completion and timeout events.
  always_comb begin
    load_s     = 1'b0;
    complete_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s = rx_dv;
      end
      ST_WAIT_CHK: begin
        if (rx_dv) begin
          complete_s = 1'b1;
        end else begin
          timeout_s = expired_s;
        end
      end
      default: begin
        load_s     = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
      end
    endcase
  end

  // A completed packet may enter the buffer when it is empty or draining now.
  assign drain_s  = pkt_valid_r && pkt_ready;
  assign accept_s = !pkt_valid_r || drain_s;

  // Data byte holding register for the packet in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r <= {BYTE_W{1'b0}};
    end else if (load_s) begin
      data_r <= rx_byte;
    end else begin
      data_r <= data_r;
    end
  end

  // Output buffer; the held packet is frozen until accepted downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_valid_r   <= 1'b0;
      pkt_data_r    <= {BYTE_W{1'b0}};
      pkt_chk_ok_r  <= 1'b0;
      overrun_err_r <= 1'b0;
    end else if (complete_s && accept_s) begin
      pkt_valid_r   <= 1'b1;
      pkt_data_r    <= data_r;
      pkt_chk_ok_r  <= chk_match(data_r, rx_byte, CHK_KEY);
      overrun_err_r <= 1'b0;
    end else if (complete_s) begin
      pkt_valid_r   <= pkt_valid_r;
      pkt_data_r    <= pkt_data_r;
      pkt_chk_ok_r  <= pkt_chk_ok_r;
      overrun_err_r <= 1'b1;
    end else if (drain_s) begin
      pkt_valid_r   <= 1'b0;
      pkt_data_r    <= pkt_data_r;
      pkt_chk_ok_r  <= pkt_chk_ok_r;
      overrun_err_r <= 1'b0;
    end else begin
      pkt_valid_r   <= pkt_valid_r;
      pkt_data_r    <= pkt_data_r;
      pkt_chk_ok_r  <= pkt_chk_ok_r;
      overrun_err_r <= 1'b0;
    end
  end

  // Registered status: timeout pulse and busy flag track the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      timeout_err_r <= timeout_s;
      busy_r        <= (state_next_s == ST_WAIT_CHK);
    end
  end

  assign pkt_valid   = pkt_valid_r;
  assign pkt_data    = pkt_data_r;
  assign pkt_chk_ok  = pkt_chk_ok_r;
  assign timeout_err = timeout_err_r;
  assign overrun_err = overrun_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Directed self-checking bench for rx_packet_assembler with a 16-cycle timeout.
module tb_rx_packet_assembler;

  logic       clock;
  logic       reset;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       pkt_ready;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_chk_ok;
  logic       timeout_err;
  logic       overrun_err;
  logic       busy;

  int n_cmp;
  int n_bad;
  int to_pulses;
  int ov_pulses;

  rx_packet_assembler #(
    .CHK_KEY        (8'h37),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .pkt_ready   (pkt_ready),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_chk_ok  (pkt_chk_ok),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Error pulses are tallied on the rising edge, i.e. one count per high cycle.
  initial begin
    to_pulses = 0;
    ov_pulses = 0;
  end
  always @(posedge clock) begin
    if (timeout_err) to_pulses <= to_pulses + 1;
    if (overrun_err) ov_pulses <= ov_pulses + 1;
  end

  // Present one byte for exactly one cycle; call and return at a falling edge.
  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clock);
    rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; pkt_ready = 1'b0;
    idle(2);
    n_cmp++; if (pkt_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %b want 0", pkt_valid); end
    n_cmp++; if (pkt_data !== 8'h00)   begin n_bad++; $display("FAIL reset_data got %h want 00", pkt_data); end
    n_cmp++; if (pkt_chk_ok !== 1'b0)  begin n_bad++; $display("FAIL reset_chk got %b want 0", pkt_chk_ok); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_to got %b want 0", timeout_err); end
    n_cmp++; if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL reset_ov got %b want 0", overrun_err); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_good_packet;
    pkt_ready = 1'b1;
    send(8'h5A);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL good_busy got %b want 1", busy); end
    send(8'h6D);
    n_cmp++; if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid got %b want 1", pkt_valid); end
    n_cmp++; if (pkt_data !== 8'h5A) begin n_bad++; $display("FAIL good_data got %h want 5a", pkt_data); end
    n_cmp++; if (pkt_chk_ok !== 1'b1) begin n_bad++; $display("FAIL good_chk got %b want 1", pkt_chk_ok); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy_end got %b want 0", busy); end
    idle(1);
    n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL good_drain got %b want 0", pkt_valid); end
  endtask

  task automatic test_bad_checksum;
    int to0, ov0;
    to0 = to_pulses; ov0 = ov_pulses;
    send(8'h10);
    send(8'hFF);
    n_cmp++; if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL bad_valid got %b want 1", pkt_valid); end
    n_cmp++; if (pkt_data !== 8'h10) begin n_bad++; $display("FAIL bad_data got %h want 10", pkt_data); end
    n_cmp++; if (pkt_chk_ok !== 1'b0) begin n_bad++; $display("FAIL bad_chk got %b want 0", pkt_chk_ok); end
    idle(2);
    n_cmp++; if ((to_pulses - to0) !== 0 || (ov_pulses - ov0) !== 0)
      begin n_bad++; $display("FAIL bad_pulses got to=%0d ov=%0d want 0/0", to_pulses - to0, ov_pulses - ov0); end
  endtask

  task automatic test_timeout;
    int to0;
    to0 = to_pulses;
    send(8'h22);
    idle(15);
    n_cmp++; if (busy !== 1'b1 || timeout_err !== 1'b0)
      begin n_bad++; $display("FAIL to_early got busy=%b to=%b want 1/0", busy, timeout_err); end
    idle(1);
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_pulse got %b want 1", timeout_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy got %b want 0", busy); end
    n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL to_valid got %b want 0", pkt_valid); end
    idle(2);
    n_cmp++; if ((to_pulses - to0) !== 1) begin n_bad++; $display("FAIL to_count got %0d want 1", to_pulses - to0); end
  endtask

  task automatic test_timeout_race;
    int to0;
    to0 = to_pulses;
    send(8'h33);
    idle(15);
    send(8'h04);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'h33 || pkt_chk_ok !== 1'b1)
      begin n_bad++; $display("FAIL race_pkt got v=%b d=%h c=%b want 1/33/1", pkt_valid, pkt_data, pkt_chk_ok); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL race_to got %b want 0", timeout_err); end
    idle(20);
    n_cmp++; if ((to_pulses - to0) !== 0) begin n_bad++; $display("FAIL race_count got %0d want 0", to_pulses - to0); end
  endtask

  task automatic test_held_strobe;
    rx_dv = 1'b1; rx_byte = 8'h11;
    @(negedge clock);
    rx_byte = 8'h26;
    @(negedge clock);
    rx_dv = 1'b0;
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'h11 || pkt_chk_ok !== 1'b1)
      begin n_bad++; $display("FAIL held_pkt got v=%b d=%h c=%b want 1/11/1", pkt_valid, pkt_data, pkt_chk_ok); end
    idle(2);
  endtask

  task automatic test_overrun;
    int ov0;
    pkt_ready = 1'b0;
    ov0 = ov_pulses;
    send(8'h01); send(8'h36);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'h01 || pkt_chk_ok !== 1'b1)
      begin n_bad++; $display("FAIL ov_first got v=%b d=%h c=%b want 1/01/1", pkt_valid, pkt_data, pkt_chk_ok); end
    send(8'h02); send(8'h35);
    n_cmp++; if (overrun_err !== 1'b1) begin n_bad++; $display("FAIL ov_pulse got %b want 1", overrun_err); end
    idle(3);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'h01)
      begin n_bad++; $display("FAIL ov_hold got v=%b d=%h want 1/01", pkt_valid, pkt_data); end
    n_cmp++; if ((ov_pulses - ov0) !== 1) begin n_bad++; $display("FAIL ov_count got %0d want 1", ov_pulses - ov0); end
    send(8'h03);
    pkt_ready = 1'b1;
    send(8'h34);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'h03 || pkt_chk_ok !== 1'b1)
      begin n_bad++; $display("FAIL ov_swap got v=%b d=%h c=%b want 1/03/1", pkt_valid, pkt_data, pkt_chk_ok); end
    n_cmp++; if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL ov_swap_err got %b want 0", overrun_err); end
    idle(2);
    n_cmp++; if ((ov_pulses - ov0) !== 1 || pkt_valid !== 1'b0)
      begin n_bad++; $display("FAIL ov_final got cnt=%0d v=%b want 1/0", ov_pulses - ov0, pkt_valid); end
  endtask

  task automatic test_reset_mid_packet;
    int to0;
    to0 = to_pulses;
    pkt_ready = 1'b1;
    send(8'h44);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    send(8'hAA);
    send(8'h9D);
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'hAA || pkt_chk_ok !== 1'b1)
      begin n_bad++; $display("FAIL rst_pkt got v=%b d=%h c=%b want 1/aa/1", pkt_valid, pkt_data, pkt_chk_ok); end
    idle(20);
    n_cmp++; if ((to_pulses - to0) !== 0) begin n_bad++; $display("FAIL rst_to got %0d want 0", to_pulses - to0); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_good_packet;
    test_bad_checksum;
    test_timeout;
    test_timeout_race;
    test_held_strobe;
    test_overrun;
    test_reset_mid_packet;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
